priority_arbiter_8ch: RTL and testbench
=======================================

Name: priority_arbiter_8ch

Overview:
- Registered 8-requester arbiter that shares one downstream resource, for example a bus port or a pipeline slot.
- Uses the same priority convention as the 8-to-3 priority encoder: bit 7 is highest, bit 0 is lowest.
- Supports fixed-priority or round-robin selection, per-owner burst holding, and a hold-time limit so that no requester starves the others.
- Sits between requesting agents and the shared resource's select mux.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one owner may hold the grant; legal range 1..255.
- CNT_WIDTH, 8: width of the internal hold counter; must satisfy 2**CNT_WIDTH > MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; req[i]=1 means requester i wants the resource.
- rr_en  input  1  0 = fixed priority, 1 = round-robin; sampled only at arbitration edges.
- grant  output  8  one-hot grant; all zero when idle.
- grant_id  output  3  binary index of the current owner; 0 when idle.
- grant_valid  output  1  1 while any grant is active.
- grant_start  output  1  one-cycle pulse in the first cycle of each new grant.

Behaviour:
- All outputs are registered; there is no combinational path from req to the outputs.
- Reset (rst=1 at a rising edge):
  - grant=0, grant_id=0, grant_valid=0, grant_start=0.
  - state=IDLE, hold_cnt=0, last_id=0.
  - Reset mid-grant drops the grant at that edge, with no release handshake.
- FSM states: IDLE and OWN.
- IDLE:
  - If req!=0 at an edge, arbitrate over req, go to OWN, load grant/grant_id, set grant_valid=1, pulse grant_start, hold_cnt=0.
  - Latency is one cycle: req applied in cycle t gives a grant visible in cycle t+1.
  - If req==0, remain in IDLE with outputs at zero.
- OWN, owner k:
  - At each edge, hold_cnt increments.
  - Release condition: req[k]==0 OR hold_cnt==MAX_HOLD-1.
  - With no release, keep the grant; grant_start=0.
  - On release, form mask = req & ~(1<<k).
  - If mask!=0: arbitrate over mask and switch directly to the new owner at that edge, with no idle gap. grant_start pulses, hold_cnt=0.
  - If mask==0: go to IDLE and clear the outputs at that edge.
  - A timed-out owner that is still requesting may therefore be re-granted only after an intervening grant or an idle cycle.
- Arbitration functions:
  - Fixed (rr_en=0): the highest set bit wins, bit 7 first.
  - Round-robin (rr_en=1): search descending starting at (last_id-1) mod 8 and wrapping 0→7; the first set bit wins.
  - last_id updates to the winner on every new grant in either mode.
  - After reset, last_id=0, so the round-robin search starts at bit 7 and the first decision matches fixed priority.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid == (grant!=0).
  - grant_id == index of the set bit.
  - grant_start is only ever 1 while grant_valid=1.
- Simultaneous events:
  - New requests arriving mid-ownership never pre-empt the owner; they are considered only at release.
  - An owner dropping req in the same cycle a higher-priority request appears leads to the higher-priority request winning at that edge.
- With MAX_HOLD=1, every grant lasts exactly one cycle, and the grant rotates each cycle while at least two requesters are active.

Test Plan:
- Reset behaviour:
  - Assert rst for 2 cycles with req=8'hFF → all outputs 0.
  - Release rst with req=8'h00 → remain idle.
- Single request, fixed mode:
  - req=8'b0000_0100 held, rr_en=0 → one cycle later grant=8'h04, grant_id=2, grant_start pulses once.
  - Grant holds 4 cycles (MAX_HOLD=4); with no other requester it drops to idle, then re-grants id 2 after one idle cycle.
- Fixed priority plus timeout:
  - req=8'b1000_0001 constant → id 7 for 4 cycles, then id 0 for 4 cycles, alternating.
  - Grant never idle; grant_start pulses at every switch.
- Round-robin fairness:
  - rr_en=1, req=8'b0010_1010 constant, from reset → owner order 5,3,1,5,3,1, each for 4 cycles.
- Early release and pre-emption rules:
  - Owner id 3 drops req on hold cycle 1 while req[6] rises in that same cycle → id 6 granted at that edge.
  - A req[7] rising mid-hold of id 6 does not interrupt id 6.
- Reset mid-grant:
  - Assert rst during OWN with id 5 → grant=0 at the next edge.
  - After release with rr_en=1 and req=8'h21 → first winner is id 5, since last_id was reset to 0.

Source files
------------

// File: rtl/priority_arbiter_8ch.sv
// priority_arbiter_8ch
// Registered 8-requester arbiter for one shared resource. Bit 7 is the
// highest priority. Fixed or round-robin selection, burst holding per
// owner, and a hold-time limit so no requester can starve the others.
module priority_arbiter_8ch #(
    parameter int MAX_HOLD  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       rr_en,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       grant_start
);

    // Reject parameter combinations the hold counter cannot represent
    generate
        if (MAX_HOLD < 1 || MAX_HOLD > 255 || (2 ** CNT_WIDTH) <= MAX_HOLD) begin : g_bad_param
            $error("priority_arbiter_8ch: illegal MAX_HOLD/CNT_WIDTH");
        end
    endgenerate

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // Value of the hold counter in the last cycle an owner may keep the grant
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);

    logic [0:0]           r_state;
    logic [CNT_WIDTH-1:0] r_hold_cnt;
    logic [2:0]           r_last_id;
    logic [7:0]           r_grant;
    logic [2:0]           r_grant_id;
    logic                 r_grant_valid;
    logic                 r_grant_start;

    logic                 w_release;
    logic [7:0]           w_arb_src;
    logic                 w_found;
    logic [2:0]           w_win_id;

    // Returns {found, id}. Fixed mode takes the highest set bit; round-robin
    // searches downward starting just below the previous winner and wraps
    // 0 -> 7, so the previous winner itself is the last candidate.
    function automatic logic [3:0] arbitrate(input logic [7:0] v,
                                             input logic       rr,
                                             input logic [2:0] last);
        logic       found;
        logic [2:0] id;
        logic [2:0] idx;
        found = 1'b0;
        id    = 3'd0;
        idx   = 3'd0;
        if (rr) begin
            for (int i = 1; i <= 8; i++) begin
                idx = last - 3'(i);
                if (!found && v[idx]) begin
                    found = 1'b1;
                    id    = idx;
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (!found && v[i]) begin
                    found = 1'b1;
                    id    = 3'(i);
                end
            end
        end
        return {found, id};
    endfunction

    // Release on owner dropping its request or on reaching the hold limit;
    // the releasing owner is masked out so a timed-out requester cannot
    // immediately win again.
    always_comb begin
        w_release = (r_state == ST_OWN) &&
                    (!req[r_grant_id] || (r_hold_cnt == HOLD_LAST));
        w_arb_src = (r_state == ST_IDLE) ? req : (req & ~r_grant);
        {w_found, w_win_id} = arbitrate(w_arb_src, rr_en, r_last_id);
    end

    // Arbitration FSM and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= '0;
            r_last_id     <= 3'd0;
            r_grant       <= 8'd0;
            r_grant_id    <= 3'd0;
            r_grant_valid <= 1'b0;
            r_grant_start <= 1'b0;
        end else if (r_state == ST_OWN && !w_release) begin
            r_hold_cnt    <= r_hold_cnt + CNT_WIDTH'(1);
            r_grant_start <= 1'b0;
        end else if (w_found) begin
            // New grant, from IDLE or as a direct hand-over from an owner
            r_state       <= ST_OWN;
            r_hold_cnt    <= '0;
            r_last_id     <= w_win_id;
            r_grant       <= 8'd1 << w_win_id;
            r_grant_id    <= w_win_id;
            r_grant_valid <= 1'b1;
            r_grant_start <= 1'b1;
        end else begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= '0;
            r_grant       <= 8'd0;
            r_grant_id    <= 3'd0;
            r_grant_valid <= 1'b0;
            r_grant_start <= 1'b0;
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign grant_start = r_grant_start;

endmodule

// File: tb/tb_priority_arbiter_8ch.sv
// tb_priority_arbiter_8ch
// Directed-vector bench with hand-computed expectations (MAX_HOLD=4).
module tb_priority_arbiter_8ch;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rr_en;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       grant_start;

    int n_checks = 0;
    int n_fail   = 0;

    priority_arbiter_8ch #(.MAX_HOLD(4), .CNT_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .rr_en       (rr_en),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .grant_start (grant_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all four outputs against an expected owner / idle state
    task automatic expect_out(input string tag, input logic vld,
                              input logic [2:0] id, input logic start);
        logic [7:0] eg;
        eg = vld ? (8'd1 << id) : 8'd0;
        chk({tag, ".grant"},       32'(grant),       32'(eg));
        chk({tag, ".grant_id"},    32'(grant_id),    32'(vld ? id : 3'd0));
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(vld));
        chk({tag, ".grant_start"}, 32'(grant_start), 32'(start));
    endtask

    // One full 4-cycle ownership by id, starting at the next edge
    task automatic expect_burst(input string tag, input logic [2:0] id);
        for (int c = 0; c < 4; c++) begin
            tick();
            expect_out(tag, 1'b1, id, c == 0);
        end
    endtask

    initial begin
        logic [2:0] rr_order [6];
        rr_order = '{3'd5, 3'd3, 3'd1, 3'd5, 3'd3, 3'd1};

        // Reset with every requester active
        rst = 1'b1; req = 8'hFF; rr_en = 1'b0;
        tick(); tick();
        expect_out("reset", 1'b0, 3'd0, 1'b0);
        rst = 1'b0; req = 8'h00;
        tick(); expect_out("idle0", 1'b0, 3'd0, 1'b0);
        tick(); expect_out("idle1", 1'b0, 3'd0, 1'b0);

        // Single requester: 4-cycle burst, one idle cycle, re-grant
        req = 8'h04;
        expect_burst("single", 3'd2);
        tick(); expect_out("single_gap", 1'b0, 3'd0, 1'b0);
        tick(); expect_out("single_regrant", 1'b1, 3'd2, 1'b1);
        req = 8'h00;
        tick(); expect_out("single_drop", 1'b0, 3'd0, 1'b0);

        // Fixed priority with timeout alternation, never idle
        req = 8'h81;
        for (int r = 0; r < 2; r++) begin
            expect_burst("fixed7", 3'd7);
            expect_burst("fixed0", 3'd0);
        end
        req = 8'h00;
        tick(); expect_out("fixed_end", 1'b0, 3'd0, 1'b0);

        // Round-robin from reset
        rst = 1'b1; tick(); rst = 1'b0;
        rr_en = 1'b1; req = 8'h2A;
        for (int k = 0; k < 6; k++) expect_burst($sformatf("rr%0d", k), rr_order[k]);
        req = 8'h00;
        tick(); expect_out("rr_end", 1'b0, 3'd0, 1'b0);

        // Early release: id 3 drops while req[6] rises -> id 6 at that edge
        rr_en = 1'b0; req = 8'h08;
        tick(); expect_out("early_own3", 1'b1, 3'd3, 1'b1);
        tick(); expect_out("early_hold3", 1'b1, 3'd3, 1'b0);
        req = 8'h40;
        tick(); expect_out("early_sw6", 1'b1, 3'd6, 1'b1);
        tick(); expect_out("hold6_1", 1'b1, 3'd6, 1'b0);
        // req[7] appears mid-hold: no pre-emption until timeout
        req = 8'hC0;
        tick(); expect_out("hold6_2", 1'b1, 3'd6, 1'b0);
        tick(); expect_out("hold6_3", 1'b1, 3'd6, 1'b0);
        tick(); expect_out("after6_7", 1'b1, 3'd7, 1'b1);
        req = 8'h00;
        tick(); expect_out("pre_end", 1'b0, 3'd0, 1'b0);

        // Reset mid-grant, then round-robin restarts from last_id=0
        rr_en = 1'b1; req = 8'h20;
        tick(); expect_out("mid_own5", 1'b1, 3'd5, 1'b1);
        tick(); expect_out("mid_hold5", 1'b1, 3'd5, 1'b0);
        rst = 1'b1;
        tick(); expect_out("mid_reset", 1'b0, 3'd0, 1'b0);
        rst = 1'b0; req = 8'h21;
        tick(); expect_out("post_rst_rr", 1'b1, 3'd5, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
